// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result queues with a round-robin grant of one head per cycle.

package cdb_arbiter_pkg;
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [5:0]  pd_s;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        valid;
    } cdb_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 3,
    parameter int unsigned QDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  cdb_t                       cdb_in [NUM_FU],
    output logic [NUM_FU-1:0]          stall,
    output cdb_t                       cdb_out,
    output logic [$clog2(NUM_FU)-1:0]  grant_idx,
    output logic                       overflow_err
);

    localparam int unsigned GW = $clog2(NUM_FU);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    cdb_t          mem_q   [NUM_FU][QDEPTH];
    cdb_t          mem_d   [NUM_FU][QDEPTH];
    logic [PW-1:0] head_q  [NUM_FU];
    logic [PW-1:0] head_d  [NUM_FU];
    logic [PW-1:0] tail_q  [NUM_FU];
    logic [PW-1:0] tail_d  [NUM_FU];
    logic [CW-1:0] count_q [NUM_FU];
    logic [CW-1:0] count_d [NUM_FU];
    logic [GW-1:0] rr_q, rr_d;
    logic          ovf_q, ovf_d;

    logic          win_v;
    logic [GW-1:0] win_idx;

    // Round-robin search over non-empty queues starting at rr_q.
    always_comb begin
        int unsigned s;
        logic [GW-1:0] idx;
        win_v   = 1'b0;
        win_idx = '0;
        s       = 0;
        idx     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            s = 32'(rr_q) + 32'(k);
            if (s >= NUM_FU) s = s - NUM_FU;
            idx = GW'(s);
            if (!win_v && count_q[idx] != '0) begin
                win_v   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Bus outputs are driven straight from the winning queue head.
    always_comb begin
        cdb_out       = '0;
        grant_idx     = win_idx;
        overflow_err  = ovf_q;
        if (win_v) begin
            cdb_out       = mem_q[win_idx][head_q[win_idx]];
            cdb_out.valid = 1'b1;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            stall[i] = (count_q[i] == CW'(QDEPTH));
        end
    end

    // Queue, pointer, round-robin and sticky-error next state.
    always_comb begin
        logic full;
        logic enq;
        logic deq;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rr_d    = rr_q;
        ovf_d   = ovf_q;
        full    = 1'b0;
        enq     = 1'b0;
        deq     = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            full = (count_q[i] == CW'(QDEPTH));
            enq  = cdb_in[i].valid && !full && !flush;
            deq  = win_v && (win_idx == GW'(i));
            if (enq) begin
                mem_d[i][tail_q[i]] = cdb_in[i];
                tail_d[i]           = PW'(tail_q[i] + 1'b1);
            end
            if (deq) begin
                head_d[i] = PW'(head_q[i] + 1'b1);
            end
            count_d[i] = CW'(count_q[i] + CW'(enq) - CW'(deq));
            if (cdb_in[i].valid && full && !flush) begin
                ovf_d = 1'b1;
            end
        end
        if (win_v) begin
            rr_d = (win_idx == GW'(NUM_FU - 1)) ? '0 : GW'(win_idx + 1'b1);
        end
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head_d[i]  = '0;
                tail_d[i]  = '0;
                count_d[i] = '0;
            end
            rr_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                for (int j = 0; j < QDEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    cdb_t       cdb_in [3];
    logic [2:0] stall;
    cdb_t       cdb_out;
    logic [1:0] grant_idx;
    logic       overflow_err;

    int checks = 0;
    int errors = 0;

    localparam cdb_t IDLE = '0;

    cdb_arbiter #(.NUM_FU(3), .QDEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .cdb_in       (cdb_in),
        .stall        (stall),
        .cdb_out      (cdb_out),
        .grant_idx    (grant_idx),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    function automatic cdb_t mk(input logic [5:0] rob, input logic [5:0] pd,
                                input logic [4:0] rd, input logic [31:0] v);
        cdb_t r;
        r.rob_idx = rob;
        r.pd_s    = pd;
        r.rd_s    = rd;
        r.rd_v    = v;
        r.valid   = 1'b1;
        return r;
    endfunction

    function automatic cdb_t mr(input logic [5:0] rob);
        return mk(rob, rob, rob[4:0], 32'hA000_0000 | {26'h0, rob});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++) cdb_in[i] = '0;
        flush = 1'b0;
    endtask

    task automatic chk_out(input string tag, input cdb_t exp_o, input logic [1:0] exp_g);
        checks++;
        assert (cdb_out === exp_o) else begin
            errors++;
            $error("FAIL %s cdb_out: got %h expected %h", tag, cdb_out, exp_o);
        end
        checks++;
        assert (grant_idx === exp_g) else begin
            errors++;
            $error("FAIL %s grant_idx: got %0d expected %0d", tag, grant_idx, exp_g);
        end
    endtask

    task automatic chk_misc(input string tag, input logic [2:0] exp_s, input logic exp_ovf);
        checks++;
        assert (stall === exp_s) else begin
            errors++;
            $error("FAIL %s stall: got %b expected %b", tag, stall, exp_s);
        end
        checks++;
        assert (overflow_err === exp_ovf) else begin
            errors++;
            $error("FAIL %s overflow_err: got %b expected %b", tag, overflow_err, exp_ovf);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // 1. reset and idle
        rst = 1'b1;
        clr();
        step();
        step();
        chk_out("reset", IDLE, 2'd0);
        chk_misc("reset", 3'b000, 1'b0);
        rst = 1'b0;
        step();
        chk_out("idle", IDLE, 2'd0);

        // 2. single add result, one-cycle latency
        cdb_in[0] = mk(6'd5, 6'd12, 5'd3, 32'hDEADBEEF);
        step();
        clr();
        chk_out("single", mk(6'd5, 6'd12, 5'd3, 32'hDEADBEEF), 2'd0);
        chk_misc("single", 3'b000, 1'b0);
        step();
        chk_out("single_after", IDLE, 2'd0);

        // 3. three-way contention from rr=0
        do_reset();
        cdb_in[0] = mr(6'd1);
        cdb_in[1] = mr(6'd2);
        cdb_in[2] = mr(6'd3);
        step();
        clr();
        chk_out("cont1", mr(6'd1), 2'd0);
        chk_misc("cont1", 3'b000, 1'b0);
        step();
        chk_out("cont2", mr(6'd2), 2'd1);
        chk_misc("cont2", 3'b000, 1'b0);
        step();
        chk_out("cont3", mr(6'd3), 2'd2);
        chk_misc("cont3", 3'b000, 1'b0);
        step();
        chk_out("cont_idle", IDLE, 2'd0);

        // 4. round-robin between busy add queue and div
        do_reset();
        cdb_in[0] = mr(6'd20);
        step();
        chk_out("rr0", mr(6'd20), 2'd0);
        cdb_in[0] = mr(6'd21);
        cdb_in[2] = mr(6'd9);
        step();
        chk_out("rr1", mr(6'd9), 2'd2);
        cdb_in[0] = mr(6'd22);
        cdb_in[2] = mr(6'd10);
        step();
        clr();
        chk_out("rr2", mr(6'd21), 2'd0);
        chk_misc("rr2", 3'b001, 1'b0);
        step();
        chk_out("rr3", mr(6'd10), 2'd2);
        step();
        chk_out("rr4", mr(6'd22), 2'd0);
        step();
        chk_out("rr_idle", IDLE, 2'd0);

        // 5. mul queue fills, third result overflows
        do_reset();
        cdb_in[0] = mr(6'd30);
        cdb_in[1] = mr(6'd41);
        step();
        chk_out("ovf1", mr(6'd30), 2'd0);
        chk_misc("ovf1", 3'b000, 1'b0);
        cdb_in[0] = mr(6'd31);
        cdb_in[1] = mr(6'd42);
        step();
        clr();
        chk_out("ovf2", mr(6'd41), 2'd1);
        chk_misc("ovf2", 3'b010, 1'b0);
        cdb_in[1] = mr(6'd43);
        step();
        clr();
        chk_out("ovf3", mr(6'd31), 2'd0);
        chk_misc("ovf3", 3'b000, 1'b1);
        step();
        chk_out("ovf4", mr(6'd42), 2'd1);
        step();
        chk_out("ovf_idle", IDLE, 2'd0);
        chk_misc("ovf_idle", 3'b000, 1'b1);

        // 6. flush drops queued and same-cycle results, keeps overflow_err
        cdb_in[0] = mr(6'd50);
        cdb_in[1] = mr(6'd51);
        step();
        clr();
        chk_out("flush_pre", mr(6'd50), 2'd0);
        flush     = 1'b1;
        cdb_in[0] = mr(6'd52);
        step();
        clr();
        chk_out("flush1", IDLE, 2'd0);
        chk_misc("flush1", 3'b000, 1'b1);
        step();
        chk_out("flush2", IDLE, 2'd0);

        // rr pointer returned to 0 after flush
        cdb_in[0] = mr(6'd60);
        cdb_in[1] = mr(6'd61);
        step();
        clr();
        chk_out("post_flush1", mr(6'd60), 2'd0);
        step();
        chk_out("post_flush2", mr(6'd61), 2'd1);
        step();
        chk_out("post_flush_idle", IDLE, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
